// File: rtl/csr_decoder_if.sv
// Bus bundle between the sparse CSR stream source and the csr_decoder.
interface csr_decoder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM    = 6,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned COL_W  = 4
);
  logic                          start;
  logic [3:0]                    row_size;
  logic [IDX_W*(DIM+1)-1:0]      index_pointer;
  logic                          in_valid;
  logic [COL_W-1:0]              in_col;
  logic [DATA_W-1:0]             in_data;
  logic [DATA_W*DIM*DIM-1:0]     map_out;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output start, row_size, index_pointer, in_valid, in_col, in_data,
    input  map_out, busy, done, err
  );

  modport slave (
    input  start, row_size, index_pointer, in_valid, in_col, in_data,
    output map_out, busy, done, err
  );
endinterface

// File: rtl/csr_decoder.sv
// Rebuilds a dense DIM x DIM map from a CSR stream (column, value) plus row pointers.
// Optional macro CSR_DEC_ZERO_CHECK_EN: zero-valued entries are rejected and flag err.
module csr_decoder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM    = 6,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned COL_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  csr_decoder_if.slave  ifc
);
  localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned RS_W  = $clog2(DIM + 1);

  typedef enum logic [1:0] {IDLE, RECV, FIN} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   map_q [DIM][DIM];
  logic [IDX_W-1:0]    ptr_q [DIM+1];
  logic [RS_W-1:0]     rs_q;
  logic [IDX_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [RS_W-1:0]     rs_c;
  logic [IDX_W-1:0]    total_c;
  logic                found_c;
  logic [ROW_W-1:0]    row_c;
  logic                col_ok_c;
  logic                data_ok_c;
  logic                last_c;

  assign rs_c     = (ifc.row_size > 4'(DIM)) ? RS_W'(DIM) : RS_W'(ifc.row_size);
  assign total_c  = ptr_q[rs_q];
  assign col_ok_c = ifc.in_col < COL_W'(DIM);
  assign last_c   = (cnt_q + IDX_W'(1)) == total_c;

`ifdef CSR_DEC_ZERO_CHECK_EN
  assign data_ok_c = ifc.in_data != '0;
`else
  assign data_ok_c = 1'b1;
`endif

  // First row whose end pointer lies beyond the entry count; empty rows fall through.
  always_comb begin
    found_c = 1'b0;
    row_c   = '0;
    for (int r = 0; r < DIM; r++) begin
      if (!found_c && (RS_W'(r) < rs_q) && (cnt_q < ptr_q[r+1])) begin
        found_c = 1'b1;
        row_c   = ROW_W'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rs_q    <= '0;
      for (int k = 0; k <= DIM; k++) ptr_q[k] <= '0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) map_q[r][c] <= '0;
    end else begin
      done_q <= 1'b0;
      if (ifc.start) begin
        // Start from any state restarts the decode; a FIN-cycle done has already pulsed.
        state_q <= RECV;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
        cnt_q   <= '0;
        rs_q    <= rs_c;
        for (int k = 0; k <= DIM; k++)
          ptr_q[k] <= ifc.index_pointer[IDX_W*(DIM+1-k)-1 -: IDX_W];
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++) map_q[r][c] <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ifc.in_valid) err_q <= 1'b1;
          end
          RECV: begin
            if (total_c == '0) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (ifc.in_valid) begin
              cnt_q <= cnt_q + IDX_W'(1);
              if (found_c && col_ok_c && data_ok_c)
                map_q[row_c][ifc.in_col[ROW_W-1:0]] <= ifc.in_data;
              else
                err_q <= 1'b1;
              if (last_c) begin
                state_q <= FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          FIN: begin
            state_q <= IDLE;
            if (ifc.in_valid) err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign ifc.map_out[DATA_W*(DIM*DIM-(r*DIM+c))-1 -: DATA_W] = map_q[r][c];
    end
  end

  assign ifc.busy = busy_q;
  assign ifc.done = done_q;
  assign ifc.err  = err_q;
endmodule

// File: tb/tb_csr_decoder.sv
// Directed testbench for csr_decoder with hand-computed expected maps.
module tb_csr_decoder;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIM    = 6;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned MAP_W  = DATA_W * DIM * DIM;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [MAP_W-1:0] exp_map;
  logic exp_err;

  always #5 clk = ~clk;

  csr_decoder_if #(.DATA_W(DATA_W), .DIM(DIM), .IDX_W(IDX_W), .COL_W(COL_W)) ifc ();

  csr_decoder #(.DATA_W(DATA_W), .DIM(DIM), .IDX_W(IDX_W), .COL_W(COL_W)) dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int r, input int c, input logic [7:0] v);
    exp_map[DATA_W*(DIM*DIM-(r*DIM+c))-1 -: DATA_W] = v;
  endtask

  task automatic drive_idle();
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_col   = '0;
    ifc.in_data  = '0;
  endtask

  task automatic drive_start(input logic [IDX_W*(DIM+1)-1:0] p, input logic [3:0] rs);
    ifc.start         = 1'b1;
    ifc.in_valid      = 1'b0;
    ifc.index_pointer = p;
    ifc.row_size      = rs;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic drive_entry(input logic [3:0] col, input logic [7:0] data);
    ifc.in_valid = 1'b1;
    ifc.in_col   = col;
    ifc.in_data  = data;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    ifc.row_size      = '0;
    ifc.index_pointer = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    n_vec++; if (ifc.map_out !== '0) begin n_err++; $display("FAIL reset_map got=%h want=0", ifc.map_out); end
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", ifc.done); end
    n_vec++; if (ifc.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", ifc.err); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
  endtask

  task automatic test_decode();
    logic [3:0] cols [4] = '{4'd2, 4'd0, 4'd5, 4'd4};
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_start({8'd0, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd4}, 4'd6);
    n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL decode_busy got=%b want=1", ifc.busy); end
    for (int i = 0; i < 4; i++) begin
      drive_entry(cols[i], vals[i]);
      n_vec++;
      if (ifc.done !== (i == 3)) begin n_err++; $display("FAIL decode_done[%0d] got=%b want=%b", i, ifc.done, (i == 3)); end
    end
    tick();
    exp_map = '0;
    set_exp(0, 2, 8'h11); set_exp(2, 0, 8'h22); set_exp(2, 5, 8'h33); set_exp(5, 4, 8'h44);
    n_vec++; if (ifc.map_out !== exp_map) begin n_err++; $display("FAIL decode_map got=%h want=%h", ifc.map_out, exp_map); end
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL decode_done_end got=%b want=0", ifc.done); end
    n_vec++; if (ifc.err !== 1'b0) begin n_err++; $display("FAIL decode_err got=%b want=0", ifc.err); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL decode_busy_end got=%b want=0", ifc.busy); end
  endtask

  task automatic test_empty();
    drive_start('0, 4'd3);
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL empty_done_early got=%b want=0", ifc.done); end
    n_vec++; if (ifc.map_out !== '0) begin n_err++; $display("FAIL empty_map_clear got=%h want=0", ifc.map_out); end
    tick();
    n_vec++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL empty_done got=%b want=1", ifc.done); end
    tick();
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL empty_done_once got=%b want=0", ifc.done); end
    n_vec++; if (ifc.err !== 1'b0) begin n_err++; $display("FAIL empty_err got=%b want=0", ifc.err); end
  endtask

  task automatic test_bad_col();
    drive_start({8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 4'd9);
    drive_entry(4'd7, 8'h99);
    n_vec++; if (ifc.err !== 1'b1) begin n_err++; $display("FAIL badcol_err got=%b want=1", ifc.err); end
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL badcol_done_early got=%b want=0", ifc.done); end
    drive_entry(4'd1, 8'h55);
    n_vec++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL badcol_done got=%b want=1", ifc.done); end
    tick();
    exp_map = '0;
    set_exp(0, 1, 8'h55);
    n_vec++; if (ifc.map_out !== exp_map) begin n_err++; $display("FAIL badcol_map got=%h want=%h", ifc.map_out, exp_map); end
    n_vec++; if (ifc.err !== 1'b1) begin n_err++; $display("FAIL badcol_sticky got=%b want=1", ifc.err); end
  endtask

  task automatic test_restart();
    drive_start({8'd0, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4}, 4'd6);
    n_vec++; if (ifc.err !== 1'b0) begin n_err++; $display("FAIL restart_err_clear got=%b want=0", ifc.err); end
    drive_entry(4'd1, 8'hAA);
    drive_entry(4'd2, 8'hBB);
    exp_map = '0;
    set_exp(0, 1, 8'hAA); set_exp(0, 2, 8'hBB);
    n_vec++; if (ifc.map_out !== exp_map) begin n_err++; $display("FAIL restart_partial got=%h want=%h", ifc.map_out, exp_map); end
    drive_start({8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 4'd1);
    n_vec++; if (ifc.map_out !== '0) begin n_err++; $display("FAIL restart_clear got=%h want=0", ifc.map_out); end
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL restart_no_done got=%b want=0", ifc.done); end
    drive_entry(4'd3, 8'h5A);
    n_vec++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL restart_done got=%b want=1", ifc.done); end
    tick();
    exp_map = '0;
    set_exp(0, 3, 8'h5A);
    n_vec++; if (ifc.map_out !== exp_map) begin n_err++; $display("FAIL restart_map got=%h want=%h", ifc.map_out, exp_map); end
    n_vec++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL restart_done_once got=%b want=0", ifc.done); end
  endtask

  task automatic test_back_to_back();
    drive_start({8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 4'd1);
    drive_entry(4'd4, 8'h10);
    drive_entry(4'd4, 8'h20);
    n_vec++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL dup_done got=%b want=1", ifc.done); end
    exp_map = '0;
    set_exp(0, 4, 8'h20);
    n_vec++; if (ifc.map_out !== exp_map) begin n_err++; $display("FAIL dup_map got=%h want=%h", ifc.map_out, exp_map); end
    n_vec++; if (ifc.err !== 1'b0) begin n_err++; $display("FAIL dup_err got=%b want=0", ifc.err); end
    tick();
  endtask

  task automatic test_zero_value();
`ifdef CSR_DEC_ZERO_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive_start({8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 4'd1);
    drive_entry(4'd1, 8'h00);
    n_vec++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b want=1", ifc.done); end
    n_vec++; if (ifc.err !== exp_err) begin n_err++; $display("FAIL zero_err got=%b want=%b", ifc.err, exp_err); end
    n_vec++; if (ifc.map_out !== '0) begin n_err++; $display("FAIL zero_map got=%h want=0", ifc.map_out); end
    tick();
  endtask

  task automatic test_idle_strobe();
    drive_entry(4'd0, 8'h01);
    n_vec++; if (ifc.err !== 1'b1) begin n_err++; $display("FAIL idle_strobe_err got=%b want=1", ifc.err); end
    n_vec++; if (ifc.map_out !== '0) begin n_err++; $display("FAIL idle_strobe_map got=%h want=0", ifc.map_out); end
    drive_start('0, 4'd0);
    n_vec++; if (ifc.err !== 1'b0) begin n_err++; $display("FAIL rs0_err_clear got=%b want=0", ifc.err); end
    n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL rs0_busy got=%b want=1", ifc.busy); end
    tick();
    n_vec++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL rs0_done got=%b want=1", ifc.done); end
    tick();
  endtask

  task automatic test_rst_mid();
    drive_start({8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, 4'd6);
    drive_entry(4'd0, 8'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (ifc.map_out !== '0) begin n_err++; $display("FAIL rstmid_map got=%h want=0", ifc.map_out); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b want=0", ifc.busy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_empty();
    test_bad_col();
    test_restart();
    test_back_to_back();
    test_zero_value();
    test_idle_strobe();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
